// File: rtl/cart_pkg.sv
// cart_pkg: shared types and constants for the cartridge image loader.
// Build option CART_AUTODETECT_EN (see cart_loader) enables signature scanning.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECIDE = 2'd2,
    READY  = 2'd3
  } state_t;

  // bank-switch scheme codes; BS_AUTO leaves the choice to the image size
  localparam logic [3:0] BS_AUTO = 4'd0;
  localparam logic [3:0] BS_F8   = 4'd1;
  localparam logic [3:0] BS_F6   = 4'd2;
  localparam logic [3:0] BS_FE   = 4'd3;
  localparam logic [3:0] BS_E0   = 4'd4;
  localparam logic [3:0] BS_3F   = 4'd5;
  localparam logic [3:0] BS_F4   = 4'd6;
  localparam logic [3:0] BS_P2   = 4'd7;
  localparam logic [3:0] BS_FA   = 4'd8;
  localparam logic [3:0] BS_CV   = 4'd9;

  // ASCII extension constants
  localparam logic [7:0]  ASCII_DOT = 8'h2E;
  localparam logic [7:0]  ASCII_S   = 8'h53;
  localparam logic [23:0] EXT_F8    = ".F8";
  localparam logic [23:0] EXT_F6    = ".F6";
  localparam logic [23:0] EXT_FE    = ".FE";
  localparam logic [23:0] EXT_E0    = ".E0";
  localparam logic [23:0] EXT_3F    = ".3F";
  localparam logic [23:0] EXT_F4    = ".F4";
  localparam logic [23:0] EXT_P2    = ".P2";
  localparam logic [23:0] EXT_FA    = ".FA";
  localparam logic [23:0] EXT_CV    = ".CV";

  // signature bytes: 85 3F marks a 3F-scheme bank write, 8D E0 1F an E0 one
  localparam logic [7:0]  SIG_3F_A    = 8'h85;
  localparam logic [7:0]  SIG_3F_B    = 8'h3F;
  localparam logic [7:0]  SIG_E0_A    = 8'h8D;
  localparam logic [7:0]  SIG_E0_B    = 8'hE0;
  localparam logic [7:0]  SIG_E0_C    = 8'h1F;
  localparam logic [24:0] SC_REGION   = 25'h80;
  localparam logic [16:0] SC_MIN_SIZE = 17'd8192;

  // three-character extension field: dot-led tail, or the leading three chars
  function automatic logic [23:0] ext_field(input logic [31:0] ext);
    return (ext[23:16] == ASCII_DOT) ? ext[23:0] : ext[31:8];
  endfunction

  function automatic logic [3:0] ext_to_bs(input logic [23:0] e);
    case (e)
      EXT_F8:  return BS_F8;
      EXT_F6:  return BS_F6;
      EXT_FE:  return BS_FE;
      EXT_E0:  return BS_E0;
      EXT_3F:  return BS_3F;
      EXT_F4:  return BS_F4;
      EXT_P2:  return BS_P2;
      EXT_FA:  return BS_FA;
      EXT_CV:  return BS_CV;
      default: return BS_AUTO;
    endcase
  endfunction

endpackage

// File: rtl/cart_sig_scan.sv
// cart_sig_scan: watches the byte stream of a download for bank-switch and
// SuperChip signatures. Only instantiated when CART_AUTODETECT_EN is defined.
module cart_sig_scan
  import cart_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        wr,
  input  logic [24:0] addr,
  input  logic [7:0]  data,
  input  logic [16:0] rom_size,
  output logic        is_3f,
  output logic        is_e0,
  output logic        is_sc
);

  logic        have_prev;
  logic [24:0] prev_addr;
  logic [7:0]  h1, h2;     // last and second-to-last byte written
  logic        prev_seq;   // h1 was sequential to h2
  logic [1:0]  cnt_3f;
  logic        seen_e0;
  logic [7:0]  b0;
  logic        have_b0;
  logic        sc_ok;
  logic        seq;

  // a byte only chains with its predecessor when the addresses are adjacent
  always_comb seq = have_prev && (addr == prev_addr + 25'd1);

  // history, pattern counters and the low-page uniformity tracker
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clr) begin
      have_prev <= 1'b0;
      prev_addr <= '0;
      h1        <= '0;
      h2        <= '0;
      prev_seq  <= 1'b0;
      cnt_3f    <= '0;
      seen_e0   <= 1'b0;
      b0        <= '0;
      have_b0   <= 1'b0;
      sc_ok     <= 1'b1;
    end else if (wr) begin
      have_prev <= 1'b1;
      prev_addr <= addr;
      h1        <= data;
      h2        <= h1;
      prev_seq  <= seq;
      if (seq && h1 == SIG_3F_A && data == SIG_3F_B && cnt_3f != 2'd3)
        cnt_3f <= cnt_3f + 2'd1;
      if (seq && prev_seq && h2 == SIG_E0_A && h1 == SIG_E0_B && data == SIG_E0_C)
        seen_e0 <= 1'b1;
      if (addr < SC_REGION) begin
        if (addr == 25'd0) begin
          b0      <= data;
          have_b0 <= 1'b1;
          if (have_b0 && data != b0) sc_ok <= 1'b0;
        end else if (!have_b0 || data != b0) begin
          sc_ok <= 1'b0;
        end
      end
    end
  end

  assign is_3f = (cnt_3f >= 2'd2);
  assign is_e0 = seen_e0;
  assign is_sc = sc_ok && have_b0 && (rom_size >= SC_MIN_SIZE);

endmodule

// File: rtl/cart_loader.sv
// cart_loader: streams a downloaded cartridge image into the ROM buffer,
// tracks its size and decodes bank-switch scheme / SuperChip from the file
// extension. Define CART_AUTODETECT_EN to add byte-signature detection.
module cart_loader
  import cart_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [31:0]       ioctl_file_ext,
  input  logic [1:0]        sc_mode,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [16:0]       rom_size,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic              cart_ready
);

  state_t      state;
  logic        dl_q;
  logic [31:0] ext_q;
  logic        dl_rise, dl_fall, load_start, in_range;
  logic [25:0] addr_p1;
  logic [16:0] wr_size;
  logic [3:0]  bs_next;
  logic        sc_auto, sc_next;

  // download edges, buffer range test and saturated write size
  always_comb begin
    dl_rise    = ioctl_download & ~dl_q;
    dl_fall    = ~ioctl_download & dl_q;
    load_start = dl_rise && (state == IDLE || state == READY);
    in_range   = ({1'b0, ioctl_addr} < (26'd1 << ADDR_W));
    addr_p1    = {1'b0, ioctl_addr} + 26'd1;
    wr_size    = (addr_p1 > 26'h1FFFF) ? 17'h1FFFF : addr_p1[16:0];
  end

`ifdef CART_AUTODETECT_EN
  logic is_3f, is_e0, is_sc;

  cart_sig_scan u_scan (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .clr      (load_start),
    .wr       (state == LOAD && ioctl_wr),
    .addr     (ioctl_addr),
    .data     (ioctl_dout),
    .rom_size (rom_size),
    .is_3f    (is_3f),
    .is_e0    (is_e0),
    .is_sc    (is_sc)
  );
`endif

  // scheme and SuperChip decision, consumed on the DECIDE -> READY step
  always_comb begin
    bs_next = ext_to_bs(ext_field(ext_q));
    sc_auto = (ext_q[7:0] == ASCII_S);
`ifdef CART_AUTODETECT_EN
    if (bs_next == BS_AUTO) begin
      if (is_3f)      bs_next = BS_3F;
      else if (is_e0) bs_next = BS_E0;
    end
    sc_auto = sc_auto | is_sc;
`endif
    case (sc_mode)
      2'd0:    sc_next = sc_auto;
      2'd1:    sc_next = 1'b0;
      default: sc_next = 1'b1;
    endcase
  end

  // loader FSM with registered buffer-write and result outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      dl_q       <= ioctl_download;  // a level held through reset is not an edge
      ext_q      <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      rom_size   <= '0;
      force_bs   <= BS_AUTO;
      sc         <= 1'b0;
      cart_ready <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      rom_we <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (dl_rise) begin
            state      <= LOAD;
            ext_q      <= ioctl_file_ext;
            rom_size   <= '0;
            force_bs   <= BS_AUTO;
            sc         <= 1'b0;
            cart_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (ioctl_wr) begin
            if (in_range) begin
              rom_we   <= 1'b1;
              rom_addr <= ioctl_addr[ADDR_W-1:0];
              rom_data <= ioctl_dout;
            end
            if (wr_size > rom_size) rom_size <= wr_size;
          end
          if (dl_fall) state <= DECIDE;
        end
        DECIDE: begin
          state      <= READY;
          force_bs   <= bs_next;
          sc         <= sc_next;
          cart_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: directed bench for cart_loader (ADDR_W=15).
module tb_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [31:0] ioctl_file_ext;
  logic [1:0]  sc_mode;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [16:0] rom_size;
  logic [3:0]  force_bs;
  logic        sc;
  logic        cart_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  cart_loader #(.ADDR_W(15)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_file_ext (ioctl_file_ext),
    .sc_mode        (sc_mode),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_size       (rom_size),
    .force_bs       (force_bs),
    .sc             (sc),
    .cart_ready     (cart_ready)
  );

  // stimulus helpers: all are entered and left at a falling clock edge
  task automatic start_dl(input logic [31:0] ext);
    ioctl_file_ext = ext;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic load_seq(input int n, input logic cfill, input logic [7:0] fill,
                          output int pulses, output int bad);
    logic [7:0] d;
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < n; i++) begin
      d = cfill ? fill : 8'(i);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = d;
      @(negedge clk_sys);
      if (rom_we === 1'b1) pulses++;
      if (rom_we !== 1'b1 || rom_addr !== 15'(i) || rom_data !== d) bad++;
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({rom_we, rom_addr, rom_data, rom_size, force_bs, sc, cart_ready} !== 48'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {rom_we, rom_addr, rom_data, rom_size, force_bs, sc, cart_ready});
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_f8();
    int p, b;
    start_dl("G.F8");
    load_seq(4096, 1'b0, 8'h00, p, b);
    checks++;
    if (p !== 4096) begin failures++; $display("FAIL f8_pulses: got %0d want 4096", p); end
    checks++;
    if (b !== 0) begin failures++; $display("FAIL f8_we_align: got %0d bad want 0", b); end
    @(negedge clk_sys);
    checks++;
    if (rom_we !== 1'b0) begin failures++; $display("FAIL f8_we_idle: got %b want 0", rom_we); end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (cart_ready !== 1'b0) begin failures++; $display("FAIL f8_ready_early: got %b want 0", cart_ready); end
    @(negedge clk_sys);
    checks++;
    if (cart_ready !== 1'b1) begin failures++; $display("FAIL f8_ready: got %b want 1", cart_ready); end
    checks++;
    if (rom_size !== 17'd4096) begin failures++; $display("FAIL f8_size: got %0d want 4096", rom_size); end
    checks++;
    if (force_bs !== 4'd1) begin failures++; $display("FAIL f8_bs: got %0d want 1", force_bs); end
    checks++;
    if (sc !== 1'b0) begin failures++; $display("FAIL f8_sc: got %b want 0", sc); end
    wr_byte(25'd5, 8'hAA);
    checks++;
    if (rom_we !== 1'b0) begin failures++; $display("FAIL ready_no_we: got %b want 0", rom_we); end
  endtask

  task automatic test_sc();
    int p, b;
    sc_mode = 2'd0;
    start_dl(".F8S");
    load_seq(8192, 1'b1, 8'hEA, p, b);
    end_dl();
    checks++;
    if (sc !== 1'b1) begin failures++; $display("FAIL sc_auto_s: got %b want 1", sc); end
    checks++;
    if ({force_bs, rom_size} !== {4'd1, 17'd8192}) begin
      failures++; $display("FAIL sc_auto_bs_size: got %0d/%0d want 1/8192", force_bs, rom_size);
    end
    sc_mode = 2'd1;
    start_dl(".F8S");
    load_seq(8192, 1'b1, 8'hEA, p, b);
    end_dl();
    checks++;
    if (sc !== 1'b0) begin failures++; $display("FAIL sc_force_off: got %b want 0", sc); end
    sc_mode = 2'd2;
    start_dl("x.F6");
    load_seq(4, 1'b0, 8'h00, p, b);
    end_dl();
    checks++;
    if ({sc, force_bs} !== {1'b1, 4'd2}) begin
      failures++; $display("FAIL sc_force_on: got %b/%0d want 1/2", sc, force_bs);
    end
    sc_mode = 2'd0;
  endtask

  task automatic test_oob();
    start_dl("G.FE");
    wr_byte(25'h8000, 8'h11);
    checks++;
    if (rom_we !== 1'b0) begin failures++; $display("FAIL oob_no_we: got %b want 0", rom_we); end
    wr_byte(25'h7FFF, 8'h22);
    checks++;
    if ({rom_we, rom_addr, rom_data} !== {1'b1, 15'h7FFF, 8'h22}) begin
      failures++; $display("FAIL top_we: got %b %h %h want 1 7fff 22", rom_we, rom_addr, rom_data);
    end
    wr_byte(25'd3, 8'h33);
    end_dl();
    checks++;
    if (rom_size !== 17'h8001) begin failures++; $display("FAIL oob_size: got %h want 8001", rom_size); end
    checks++;
    if (force_bs !== 4'd3) begin failures++; $display("FAIL fe_bs: got %0d want 3", force_bs); end
    start_dl("G.FE");
    wr_byte(25'h1FFFFFF, 8'h00);
    wr_byte(25'h10, 8'h00);
    end_dl();
    checks++;
    if (rom_size !== 17'h1FFFF) begin failures++; $display("FAIL size_sat: got %h want 1ffff", rom_size); end
  endtask

  task automatic test_ext_table();
    logic [31:0] exts [12] = '{"x.F8", "x.F6", "x.FE", "x.E0", "x.3F", "x.F4",
                               "x.P2", "x.FA", "x.CV", ".E0S", "ABCD", "x.f8"};
    logic [3:0]  exp_bs [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                 4'd7, 4'd8, 4'd9, 4'd4, 4'd0, 4'd0};
    logic        exp_sc [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      start_dl(exts[k]);
      wr_byte(25'd0, 8'h00);
      end_dl();
      checks++;
      if (force_bs !== exp_bs[k]) begin
        failures++; $display("FAIL ext_bs[%0d]: got %0d want %0d", k, force_bs, exp_bs[k]);
      end
      checks++;
      if (sc !== exp_sc[k]) begin
        failures++; $display("FAIL ext_sc[%0d]: got %b want %b", k, sc, exp_sc[k]);
      end
    end
  endtask

  task automatic test_bin();
    logic [7:0] img [8] = '{8'h00, 8'h85, 8'h3F, 8'h00, 8'h00, 8'h85, 8'h3F, 8'h00};
    logic [3:0] want;
`ifdef CART_AUTODETECT_EN
    want = 4'd5;
`else
    want = 4'd0;
`endif
    start_dl(".BIN");
    for (int k = 0; k < 8; k++) wr_byte(25'(k), img[k]);
    end_dl();
    checks++;
    if (force_bs !== want) begin failures++; $display("FAIL bin_bs: got %0d want %0d", force_bs, want); end
  endtask

  task automatic test_reset_mid();
    int p, b;
    start_dl("G.F4");
    load_seq(100, 1'b0, 8'h00, p, b);
    reset_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({rom_we, rom_addr, rom_data, rom_size, force_bs, sc, cart_ready} !== 48'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h want 0",
               {rom_we, rom_addr, rom_data, rom_size, force_bs, sc, cart_ready});
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    wr_byte(25'd7, 8'h55);
    checks++;
    if ({rom_we, rom_size} !== 18'd0) begin
      failures++; $display("FAIL no_restart: got we=%b size=%0d want 0/0", rom_we, rom_size);
    end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (cart_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: got %b want 0", cart_ready); end
    start_dl("G.F4");
    load_seq(3, 1'b0, 8'h00, p, b);
    end_dl();
    checks++;
    if ({cart_ready, force_bs, rom_size} !== {1'b1, 4'd6, 17'd3}) begin
      failures++; $display("FAIL reload: got %b/%0d/%0d want 1/6/3", cart_ready, force_bs, rom_size);
    end
  endtask

  task automatic test_back_to_back();
    start_dl("G.P2");
    checks++;
    if ({cart_ready, rom_size, force_bs} !== 22'd0) begin
      failures++; $display("FAIL b2b_clear: got %b/%0d/%0d want 0/0/0", cart_ready, rom_size, force_bs);
    end
    wr_byte(25'd4, 8'h01);
    end_dl();
    checks++;
    if ({rom_size, force_bs, cart_ready} !== {17'd5, 4'd7, 1'b1}) begin
      failures++; $display("FAIL b2b_result: got %0d/%0d/%b want 5/7/1", rom_size, force_bs, cart_ready);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_file_ext = '0;
    sc_mode        = 2'd0;
    @(negedge clk_sys);
    test_reset();
    test_f8();
    test_sc();
    test_oob();
    test_ext_table();
    test_bin();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the ROM write address width (cartridge image buffer of 2^ADDR_W bytes).
REQ-002 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 reset_n  in  1  reset: one clock, synchronous, active-low.
REQ-004 ioctl_download  in  1  high while an image download is in progress.
REQ-005 ioctl_wr  in  1  one-cycle byte strobe.
REQ-006 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-007 ioctl_dout  in  8  image byte.
REQ-008 ioctl_file_ext  in  32  last four filename characters, ASCII, last character in [7:0].
REQ-009 sc_mode  in  2  SuperChip option: 0 auto, 1 force off, 2 or 3 force on.
REQ-010 rom_we  out  1  buffer write strobe.
REQ-011 rom_addr  out  ADDR_W  buffer write address.
REQ-012 rom_data  out  8  buffer write data.
REQ-013 rom_size  out  17  image length in bytes.
REQ-014 force_bs  out  4  bank-switch scheme code; 0 means by-size default.
REQ-015 sc  out  1  SuperChip RAM enable.
REQ-016 cart_ready  out  1  high while a decoded image is valid.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, DECIDE and READY.
REQ-018 A rising edge of ioctl_download, from IDLE or READY, SHALL do all of the following:
- enter LOAD;
- clear rom_size, force_bs, sc, cart_ready and the signature state;
- latch ioctl_file_ext.
REQ-019 In LOAD, each ioctl_wr with ioctl_addr < 2^ADDR_W SHALL produce rom_we=1 exactly one cycle later, with rom_addr and rom_data registered from that write.
REQ-020 Writes with ioctl_addr >= 2^ADDR_W SHALL NOT assert rom_we, but SHALL still update rom_size.
REQ-021 On each write, rom_size SHALL become max(rom_size, ioctl_addr+1), saturating at 17'h1FFFF.
REQ-022 A falling edge of ioctl_download in LOAD SHALL enter DECIDE for exactly one cycle, then READY.
REQ-023 On entering READY, force_bs and sc SHALL be registered and cart_ready SHALL be set to 1.
REQ-024 Extension field E (24 bits) SHALL be ext[23:0] if ext[23:16]==".", otherwise ext[31:8].
REQ-025 force_bs SHALL be decoded from E as follows; any other value gives 0.

| E | force_bs |
|---|---|
| .F8 | 1 |
| .F6 | 2 |
| .FE | 3 |
| .E0 | 4 |
| .3F | 5 |
| .F4 | 6 |
| .P2 | 7 |
| .FA | 8 |
| .CV | 9 |

REQ-026 sc SHALL be 0 if sc_mode==1, SHALL be 1 if sc_mode>=2, and otherwise (auto) SHALL be 1 iff ext[7:0]=="S" or the SuperChip signature matched (REQ-031).
REQ-027 rom_we SHALL be 0 in every state other than the cycle following a qualifying write in LOAD.
REQ-028 A new rising edge of ioctl_download while in LOAD SHALL be ignored, because an edge cannot occur while the level is already high.

Configuration
REQ-029 Macro CART_AUTODETECT_EN, when defined, SHALL enable signature scanning during LOAD. A byte is "sequential" only when its ioctl_addr equals the previous write's address+1.
REQ-030 With CART_AUTODETECT_EN, if the extension gives 0, then:
- force_bs=5 SHALL result when sequential pair 85 3F is seen at least twice (counter saturating at 3);
- otherwise force_bs=4 SHALL result when sequential triple 8D E0 1F is seen.
REQ-031 With CART_AUTODETECT_EN, the SuperChip signature SHALL match when bytes 0x000-0x07F are all equal and rom_size >= 8192.
REQ-032 Without CART_AUTODETECT_EN, no scan logic SHALL exist, and the decode SHALL use only the extension and sc_mode.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL enter IDLE and clear rom_we, rom_addr, rom_data, rom_size, force_bs, sc, cart_ready and all signature state.
REQ-034 If reset_n is asserted mid-LOAD, the partial image SHALL be abandoned. After reset, loading SHALL restart only on a fresh rising edge of ioctl_download.

Structure
REQ-035 Package cart_pkg SHALL hold:
- the FSM state typedef;
- the force_bs code constants (BS_AUTO=0 .. BS_CV=9);
- the ASCII extension constants;
- the signature byte constants.
REQ-036 Signature scanning SHALL live in one sub-module, cart_sig_scan. It is instantiated only under CART_AUTODETECT_EN, and outputs is_3f, is_e0 and is_sc.

Verification
REQ-037 Download 4096 sequential bytes with ext ".F8" -> rom_we pulses 4096 times, each one cycle after its ioctl_wr; rom_size=4096; force_bs=1; cart_ready=1 two cycles after download falls.
REQ-038 sc_mode=0, ext ".F8S", 8 KB image -> sc=1; same case with sc_mode=1 -> sc=0.
REQ-039 Write to ioctl_addr 0x8000 with ADDR_W=15 -> no rom_we; rom_size=0x8001.
REQ-040 With CART_AUTODETECT_EN, ext ".BIN", image containing 85 3F twice -> force_bs=5; without the macro, the same image -> force_bs=0.
REQ-041 Assert reset_n=0 after 100 bytes of LOAD -> next cycle state IDLE with all outputs 0; a later download decodes normally.
REQ-042 Start a second download while in READY -> cart_ready drops the next cycle and rom_size restarts from 0.
